// File: rtl/uart_rx_hsk.sv
// 8N1 UART receiver with a one-byte holding register handed off over a 4-phase req/ack handshake.
// Optional even-parity frames (11 bits, extra out_parity_err pulse) when UART_RX_PARITY_EN is defined.
module uart_rx_hsk #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_rx,
    input  logic       in_rx_enable,
    output logic [7:0] out_data_rx,
    output logic       out_data_rx_hsk_req,
    input  logic       in_data_rx_hsk_ack,
    output logic       out_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       out_parity_err,
`endif
    output logic       out_overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {H_EMPTY, H_FULL, H_REQ, H_WAIT_ACK_LOW} hs_state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs_prev_q, rxs_prev_d;
    rx_state_t              rx_state_q, rx_state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    hs_state_t              hs_state_q, hs_state_d;
    logic [7:0]             data_q, data_d;
    logic                   req_q, req_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rxs;
    logic                   byte_valid;
    logic                   frame_bad;
    logic                   parity_bad;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   parity_err_q, parity_err_d;
`endif

    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], in_rx};
        rxs_prev_d = rxs;
        rx_state_d = rx_state_q;
        timer_d    = timer_q + TW'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_bad  = 1'b0;
        parity_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                timer_d = '0;
                if (rxs_prev_q && !rxs) rx_state_d = RX_START;
            end
            RX_START: begin
                if (timer_q == T_HALF) begin
                    timer_d    = '0;
                    bit_cnt_d  = '0;
                    rx_state_d = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d   = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
`else
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (timer_q == T_FULL) begin
                    timer_d    = '0;
                    par_bad_d  = rxs ^ (^shift_q);
                    rx_state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                // Decide in the sample cycle; the rest of the stop bit is spent in IDLE.
                if (timer_q == T_FULL) begin
                    timer_d    = '0;
                    rx_state_d = RX_IDLE;
                    if (!rxs) frame_bad = 1'b1;
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) parity_bad = 1'b1;
`endif
                    else byte_valid = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        hs_state_d  = hs_state_q;
        data_d      = data_q;
        req_d       = req_q;
        overrun_d   = 1'b0;
        frame_err_d = frame_bad;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_bad;
`endif
        case (hs_state_q)
            H_EMPTY: begin
                if (byte_valid) begin
                    data_d     = shift_q;
                    req_d      = in_rx_enable;
                    hs_state_d = in_rx_enable ? H_REQ : H_FULL;
                end
            end
            H_FULL: begin
                overrun_d = byte_valid;
                if (in_rx_enable) begin
                    req_d      = 1'b1;
                    hs_state_d = H_REQ;
                end
            end
            H_REQ: begin
                overrun_d = byte_valid;
                if (in_data_rx_hsk_ack) begin
                    req_d      = 1'b0;
                    hs_state_d = H_WAIT_ACK_LOW;
                end
            end
            H_WAIT_ACK_LOW: begin
                if (!in_data_rx_hsk_ack) begin
                    // A byte landing as the handshake closes is accepted, not an overrun.
                    hs_state_d = H_EMPTY;
                    if (byte_valid) begin
                        data_d     = shift_q;
                        req_d      = in_rx_enable;
                        hs_state_d = in_rx_enable ? H_REQ : H_FULL;
                    end
                end else begin
                    overrun_d = byte_valid;
                end
            end
            default: hs_state_d = H_EMPTY;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            sync_q      <= '1;
            rxs_prev_q  <= 1'b1;
            rx_state_q  <= RX_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hs_state_q  <= H_EMPTY;
            data_q      <= '0;
            req_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            rxs_prev_q  <= rxs_prev_d;
            rx_state_q  <= rx_state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hs_state_q  <= hs_state_d;
            data_q      <= data_d;
            req_q       <= req_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out_data_rx         = data_q;
    assign out_data_rx_hsk_req = req_q;
    assign out_frame_err       = frame_err_q;
    assign out_overrun         = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign out_parity_err      = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_hsk.sv
// Self-checking bench for uart_rx_hsk: scoreboard of expected bytes popped at each req rise.
// Define UART_RX_PARITY_EN on both files to exercise the parity build.
module tb_uart_rx_hsk;

    localparam int CPB    = 16;
    localparam int CLK_P  = 10;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS  = 1;
`else
    localparam int PBITS  = 0;
`endif
    // 2 sync flops + 1 edge-detect cycle + half a bit to mid-start, then 8 data (+parity) + stop bits.
    localparam int REQ_LAT = 3 + CPB / 2 + CPB * (9 + PBITS);

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rx_en;
    logic [7:0] data;
    logic       req;
    logic       ack;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_hsk #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .in_clk             (clk),
        .in_rst             (rst_n),
        .in_rx              (rx),
        .in_rx_enable       (rx_en),
        .out_data_rx        (data),
        .out_data_rx_hsk_req(req),
        .in_data_rx_hsk_ack (ack),
        .out_frame_err      (frame_err),
`ifdef UART_RX_PARITY_EN
        .out_parity_err     (parity_err),
`endif
        .out_overrun        (overrun)
    );

    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         pe_cnt = 0;
    int         req_cnt = 0;
    longint     req_rise_time = 0;
    longint     frame_t0 = 0;
    logic [7:0] exp_q[$];
    logic [7:0] held = 8'h00;
    logic       req_prev = 1'b0;
    bit         auto_ack = 1'b0;

    // Monitor: counts pulses, pops the scoreboard at every req rise, checks data held stable.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            if (req && !req_prev) begin
                req_cnt++;
                req_rise_time = $time;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_req: got data=%02h, required no request", data);
                    held = data;
                end else begin
                    e = exp_q.pop_front();
                    held = e;
                    if (data !== e) begin
                        bad++;
                        $display("FAIL req_data: got %02h, required %02h", data, e);
                    end
                end
            end else if (req && req_prev) begin
                total++;
                if (data !== held) begin
                    bad++;
                    $display("FAIL data_stable: got %02h, required %02h", data, held);
                end
            end
            req_prev = req;
        end
    end

    // Handshake agent: ack 2 cycles after req, drop ack 2 cycles after req falls.
    initial begin
        int n;
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ack && req && !ack) begin
                repeat (2) @(negedge clk);
                ack = 1'b1;
                n = 0;
                while (req && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                total++;
                if (req) begin
                    bad++;
                    $display("FAIL req_release: got req=1 after %0d cycles, required 0", n);
                end
                repeat (2) @(negedge clk);
                ack = 1'b0;
            end
        end
    end

    initial begin
        #(200000 * CLK_P);
        $display("FAIL watchdog: got no finish by cycle 200000, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        rx = 1'b0;
        frame_t0 = $time;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(par_b);
`endif
        hold_bit(stop_b);
        hold_bit(1'b1);
        if (par_b === 1'bx) rx = 1'b1;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || req || ack) && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0 || req || ack) begin
            bad++;
            $display("FAIL %s_drain: got pending=%0d req=%b ack=%b, required 0 0 0", name, exp_q.size(), req, ack);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        rx_en = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({data, req, frame_err, overrun} !== 11'd0) begin
            bad++;
            $display("FAIL reset_in: got data=%02h req=%b fe=%b ov=%b, required all 0", data, req, frame_err, overrun);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({data, req, frame_err, overrun} !== 11'd0) begin
            bad++;
            $display("FAIL reset_after: got data=%02h req=%b fe=%b ov=%b, required all 0", data, req, frame_err, overrun);
        end
    endtask

    task automatic test_basic();
        int fe0 = fe_cnt, ov0 = ov_cnt, pe0 = pe_cnt, rq0 = req_cnt;
        auto_ack = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        total++;
        if (req_cnt != rq0 + 1) begin
            bad++;
            $display("FAIL basic_req_count: got %0d, required %0d", req_cnt - rq0, 1);
        end
        total++;
        if (req_rise_time - frame_t0 != longint'(REQ_LAT * CLK_P)) begin
            bad++;
            $display("FAIL basic_latency: got %0d, required %0d", req_rise_time - frame_t0, REQ_LAT * CLK_P);
        end
        wait_drained("basic");
        total++;
        if (fe_cnt != fe0 || ov_cnt != ov0 || pe_cnt != pe0 || data !== 8'hA5) begin
            bad++;
            $display("FAIL basic_after: got fe=%0d ov=%0d pe=%0d data=%02h, required 0 0 0 a5",
                     fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0, data);
        end
    endtask

    task automatic test_frame_err();
        int fe0 = fe_cnt, ov0 = ov_cnt, rq0 = req_cnt;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        total++;
        if (fe_cnt != fe0 + 1 || ov_cnt != ov0) begin
            bad++;
            $display("FAIL frame_err_pulse: got fe=%0d ov=%0d, required 1 0", fe_cnt - fe0, ov_cnt - ov0);
        end
        total++;
        if (req_cnt != rq0 || req !== 1'b0 || data !== 8'hA5) begin
            bad++;
            $display("FAIL frame_err_drop: got reqs=%0d req=%b data=%02h, required 0 0 a5", req_cnt - rq0, req, data);
        end
    endtask

    task automatic test_overrun();
        int ov0 = ov_cnt, fe0 = fe_cnt;
        auto_ack = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, ^8'h11);
        total++;
        if (req !== 1'b1 || data !== 8'h11) begin
            bad++;
            $display("FAIL overrun_first: got req=%b data=%02h, required 1 11", req, data);
        end
        send_frame(8'h22, 1'b1, ^8'h22);
        total++;
        if (ov_cnt != ov0 + 1 || fe_cnt != fe0) begin
            bad++;
            $display("FAIL overrun_pulse: got ov=%0d fe=%0d, required 1 0", ov_cnt - ov0, fe_cnt - fe0);
        end
        total++;
        if (data !== 8'h11 || req !== 1'b1) begin
            bad++;
            $display("FAIL overrun_hold: got data=%02h req=%b, required 11 1", data, req);
        end
        auto_ack = 1'b1;
        wait_drained("overrun_ack");
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, ^8'h33);
        wait_drained("overrun_next");
        total++;
        if (data !== 8'h33 || ov_cnt != ov0 + 1) begin
            bad++;
            $display("FAIL overrun_next: got data=%02h ov=%0d, required 33 1", data, ov_cnt - ov0);
        end
    endtask

    task automatic test_glitch();
        int fe0 = fe_cnt, ov0 = ov_cnt, pe0 = pe_cnt, rq0 = req_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        total++;
        if (req_cnt != rq0 || req !== 1'b0 || fe_cnt != fe0 || ov_cnt != ov0 || pe_cnt != pe0) begin
            bad++;
            $display("FAIL glitch: got reqs=%0d fe=%0d ov=%0d pe=%0d, required 0 0 0 0",
                     req_cnt - rq0, fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0);
        end
    endtask

    task automatic test_enable();
        int rq0 = req_cnt;
        auto_ack = 1'b0;
        rx_en = 1'b0;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, ^8'h7E);
        repeat (5) @(negedge clk);
        total++;
        if (req !== 1'b0 || req_cnt != rq0) begin
            bad++;
            $display("FAIL enable_gate: got req=%b reqs=%0d, required 0 0", req, req_cnt - rq0);
        end
        rx_en = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (req !== 1'b1 || req_cnt != rq0 + 1 || data !== 8'h7E) begin
            bad++;
            $display("FAIL enable_req: got req=%b reqs=%0d data=%02h, required 1 1 7e", req, req_cnt - rq0, data);
        end
        rx_en = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (req !== 1'b1) begin
            bad++;
            $display("FAIL enable_drop_in_req: got req=%b, required 1", req);
        end
        rx_en = 1'b1;
        auto_ack = 1'b1;
        wait_drained("enable");
    endtask

    task automatic test_reset_mid();
        auto_ack = 1'b1;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) hold_bit(i[0]);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (data !== 8'h00 || req !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_data: got data=%02h req=%b, required 00 0", data, req);
        end
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, ^8'h0F);
        wait_drained("reset_mid");
        total++;
        if (data !== 8'h0F) begin
            bad++;
            $display("FAIL reset_mid_next: got %02h, required 0f", data);
        end
        auto_ack = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (req !== 1'b0 || data !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_hsk: got req=%b data=%02h, required 0 00", req, data);
        end
        rst_n = 1'b1;
        auto_ack = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int fe0 = fe_cnt, pe0 = pe_cnt, rq0 = req_cnt;
        send_frame(8'h0F, 1'b1, 1'b1);
        total++;
        if (pe_cnt != pe0 + 1 || fe_cnt != fe0 || req_cnt != rq0) begin
            bad++;
            $display("FAIL parity_err: got pe=%0d fe=%0d reqs=%0d, required 1 0 0", pe_cnt - pe0, fe_cnt - fe0, req_cnt - rq0);
        end
        send_frame(8'h0F, 1'b0, 1'b1);
        total++;
        if (pe_cnt != pe0 + 1 || fe_cnt != fe0 + 1 || req_cnt != rq0) begin
            bad++;
            $display("FAIL parity_and_stop: got pe=%0d fe=%0d reqs=%0d, required 1 1 0", pe_cnt - pe0, fe_cnt - fe0, req_cnt - rq0);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        rx_en = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_enable();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        repeat (4) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
